// File: rtl/game_pkg.sv
// Shared encodings for the maze game timer/scoreboard: FSM states,
// seven-segment glyphs and the decimal digit segment table.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_WIN  = 2'b10,
    ST_LOSE = 2'b11
  } state_e;

  // Segment bit order is {dp,g,f,e,d,c,b,a}, active-high; dp is never lit.
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_DASH  = 8'h40;
  localparam logic [7:0] SEG_RUN   = 8'h50;  // 'r'
  localparam logic [7:0] SEG_WIN   = 8'h73;  // 'P'
  localparam logic [7:0] SEG_LOSE  = 8'h38;  // 'L'

  // Decimal digit to segment pattern; non-decimal codes render blank.
  function automatic logic [7:0] digit_seg(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'h3F;
      4'd1:    s = 8'h06;
      4'd2:    s = 8'h5B;
      4'd3:    s = 8'h4F;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'h6D;
      4'd6:    s = 8'h7D;
      4'd7:    s = 8'h07;
      4'd8:    s = 8'h7F;
      4'd9:    s = 8'h6F;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Glyph shown in the leftmost digit for each game state.
  function automatic logic [7:0] state_glyph(input state_e st);
    logic [7:0] s;
    case (st)
      ST_IDLE: s = SEG_DASH;
      ST_RUN:  s = SEG_RUN;
      ST_WIN:  s = SEG_WIN;
      default: s = SEG_LOSE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_bcd_decode.sv
// Combinational 7-bit binary to 3-digit BCD converter (double-dabble).
// Output is {hundreds, tens, ones}, one nibble each.
module seg_bcd_decode (
  input  logic [6:0]  bin_i,
  output logic [11:0] bcd_o
);

  logic [11:0] bcd_d;

  // Shift binary bits in MSB-first, adding 3 to any nibble above 4 beforehand.
  always_comb begin
    bcd_d = '0;
    for (int i = 6; i >= 0; i--) begin
      if (bcd_d[3:0] > 4'd4) bcd_d[3:0] = bcd_d[3:0] + 4'd3;
      if (bcd_d[7:4] > 4'd4) bcd_d[7:4] = bcd_d[7:4] + 4'd3;
      bcd_d = {bcd_d[10:0], bin_i[i]};
    end
  end

  assign bcd_o = bcd_d;

endmodule

// File: rtl/game_timer_display.sv
// Countdown game timer plus 8-digit multiplexed seven-segment scoreboard.
// Runs the IDLE/RUN/WIN/LOSE game FSM, the one-second prescaler, and the
// display scan that shows step count, seconds left and a state glyph.
module game_timer_display
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned SCAN_DIV  = 50_000,
  parameter int unsigned START_SEC = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       suc,
  input  logic [6:0] step_cnt,
  output logic [4:0] time_sign,
  output logic [1:0] state,
  output logic [7:0] seg,
  output logic [7:0] cat
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [4:0]    START_V    = 5'(START_SEC);

  state_e        state_q;
  logic [4:0]    time_q;
  logic [PW-1:0] presc_q;
  logic [SW-1:0] scan_q;
  logic [2:0]    idx_q;
  logic          start_q;
  logic [7:0]    seg_q, seg_d;
  logic [7:0]    cat_q, cat_d;
  logic          go;
  logic          tick;
  logic [11:0]   step_bcd;
  logic [11:0]   time_bcd;
  logic          time_hund_unused;

  // Previous start level, used for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) start_q <= 1'b0;
    else      start_q <= start;
  end

  assign go   = start & ~start_q;
  assign tick = (state_q == ST_RUN) && (presc_q == PRESC_LAST);

  // Game FSM with countdown and prescaler; a start edge restarts from any state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      time_q  <= START_V;
      presc_q <= '0;
    end else if (go) begin
      state_q <= ST_RUN;
      time_q  <= START_V;
      presc_q <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (suc) begin
            // Reaching the goal wins even on a tick cycle; time stays frozen.
            state_q <= ST_WIN;
            presc_q <= '0;
          end else if (tick) begin
            presc_q <= '0;
            if (time_q <= 5'd1) begin
              time_q  <= 5'd0;
              state_q <= ST_LOSE;
            end else begin
              time_q <= time_q - 5'd1;
            end
          end else begin
            presc_q <= presc_q + 1'b1;
          end
        end
        default: presc_q <= '0;
      endcase
    end
  end

  // Digit slot timer and digit index; free-running in every state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_q <= '0;
      idx_q  <= '0;
    end else if (scan_q == SCAN_LAST) begin
      scan_q <= '0;
      idx_q  <= idx_q + 3'd1;
    end else begin
      scan_q <= scan_q + 1'b1;
    end
  end

  seg_bcd_decode u_step_bcd (
    .bin_i (step_cnt),
    .bcd_o (step_bcd)
  );

  seg_bcd_decode u_time_bcd (
    .bin_i ({2'b00, time_q}),
    .bcd_o (time_bcd)
  );

  // Time never exceeds 31 s, so its hundreds digit is always zero.
  assign time_hund_unused = ^time_bcd[11:8];

  // Select the segment pattern for the digit currently being scanned.
  always_comb begin
    seg_d = SEG_BLANK;
    case (idx_q)
      3'd0: seg_d = digit_seg(step_bcd[3:0]);
      3'd1: seg_d = (step_bcd[11:4] == 8'd0) ? SEG_BLANK : digit_seg(step_bcd[7:4]);
      3'd2: seg_d = (step_bcd[11:8] == 4'd0) ? SEG_BLANK : digit_seg(step_bcd[11:8]);
      3'd4: seg_d = digit_seg(time_bcd[3:0]);
      3'd5: seg_d = digit_seg(time_bcd[7:4]);
      3'd7: seg_d = state_glyph(state_q);
      default: seg_d = SEG_BLANK;
    endcase
    // Before the first game, numeric digits show dashes instead of values.
    if (state_q == ST_IDLE && idx_q != 3'd3 && idx_q != 3'd6 && idx_q != 3'd7) begin
      seg_d = SEG_DASH;
    end
    cat_d = ~(8'b1 << idx_q);
  end

  // Registered display drive, one clock behind the digit index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_q <= SEG_BLANK;
      cat_q <= 8'hFF;
    end else begin
      seg_q <= seg_d;
      cat_q <= cat_d;
    end
  end

  assign time_sign = time_q;
  assign state     = state_q;
  assign seg       = seg_q;
  assign cat       = cat_q;

endmodule

// File: tb/tb_game_timer_display.sv
// Bench for game_timer_display: an arithmetic reference model checked every
// clock, directed scenarios with literal expectations, then random play.
module tb_game_timer_display;

  localparam int TICK_DIV  = 10;
  localparam int SCAN_DIV  = 2;
  localparam int START_SEC = 3;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic       start    = 1'b0;
  logic       suc      = 1'b0;
  logic [6:0] step_cnt = 7'd0;
  logic [4:0] time_sign;
  logic [1:0] state;
  logic [7:0] seg;
  logic [7:0] cat;

  int total = 0;
  int bad   = 0;

  logic [7:0] seg_tbl [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                               8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  // model state: 0 idle, 1 run, 2 win, 3 lose
  int         m_state, m_time, m_cyc, m_scan, m_idx;
  bit         m_prev;
  logic [7:0] m_seg, m_cat;

  game_timer_display #(
    .TICK_DIV  (TICK_DIV),
    .SCAN_DIV  (SCAN_DIV),
    .START_SEC (START_SEC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .suc       (suc),
    .step_cnt  (step_cnt),
    .time_sign (time_sign),
    .state     (state),
    .seg       (seg),
    .cat       (cat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_seg(input int idx, input int st, input int t, input int s);
    if (idx == 7) begin
      case (st)
        0: return 8'h40;
        1: return 8'h50;
        2: return 8'h73;
        default: return 8'h38;
      endcase
    end
    if (idx == 3 || idx == 6) return 8'h00;
    if (st == 0) return 8'h40;
    case (idx)
      0: return seg_tbl[s % 10];
      1: return (s >= 10) ? seg_tbl[(s / 10) % 10] : 8'h00;
      2: return (s >= 100) ? seg_tbl[s / 100] : 8'h00;
      4: return seg_tbl[t % 10];
      default: return seg_tbl[(t / 10) % 10];
    endcase
  endfunction

  // Reference model update and per-cycle compare.
  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_state = 0; m_time = START_SEC; m_cyc = 0;
        m_scan = 0; m_idx = 0; m_prev = 1'b0;
        m_seg = 8'h00; m_cat = 8'hFF;
      end else begin : step
        bit go, tick;
        go     = start && !m_prev;
        m_prev = start;
        m_seg  = exp_seg(m_idx, m_state, m_time, int'(step_cnt));
        m_cat  = ~(8'h01 << m_idx);
        if (m_scan == SCAN_DIV - 1) begin
          m_scan = 0;
          m_idx  = (m_idx + 1) % 8;
        end else begin
          m_scan++;
        end
        tick = (m_state == 1) && (m_cyc == TICK_DIV - 1);
        if (go) begin
          m_state = 1; m_time = START_SEC; m_cyc = 0;
        end else if (m_state == 1) begin
          if (suc) begin
            m_state = 2; m_cyc = 0;
          end else if (tick) begin
            m_cyc  = 0;
            m_time = m_time - 1;
            if (m_time == 0) m_state = 3;
          end else begin
            m_cyc++;
          end
        end else begin
          m_cyc = 0;
        end
      end
      #1;
      check("model_state", int'(state), m_state);
      check("model_time",  int'(time_sign), m_time);
      check("model_seg",   int'(seg), int'(m_seg));
      check("model_cat",   int'(cat), int'(m_cat));
    end
  end

  // Wait (bounded) for a given digit select, then check its segments.
  task automatic wait_cat(input logic [7:0] want_cat, input logic [7:0] want_seg, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (cat == want_cat) found = 1'b1;
    end
    if (found) begin
      check(name, int'(seg), int'(want_seg));
    end else begin
      total++;
      bad++;
      $display("FAIL %s: cat %0h never seen, last cat %0h", name, want_cat, cat);
    end
  endtask

  // Rising start edge seen at the next posedge (P0); returns just after P0 with start low.
  task automatic start_game();
    @(negedge clk) start = 1'b1;
    @(posedge clk); #2;
    check("go_state", int'(state), 1);
    check("go_time", int'(time_sign), START_SEC);
    @(negedge clk) start = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset then idle
    repeat (3) @(negedge clk);
    rst = 1'b1;
    cycles(100);
    check("t1_state", int'(state), 0);
    check("t1_time", int'(time_sign), 3);
    wait_cat(8'h7F, 8'h40, "t1_glyph_idle");
    wait_cat(8'hFE, 8'h40, "t1_step_dash");

    // 2: countdown to LOSE
    start_game();
    cycles(9);  check("t2_p9_time", int'(time_sign), 3);
    cycles(1);  check("t2_p10_time", int'(time_sign), 2);
    cycles(10); check("t2_p20_time", int'(time_sign), 1);
    cycles(9);  check("t2_p29_state", int'(state), 1);
    cycles(1);  check("t2_p30_state", int'(state), 3);
    check("t2_p30_time", int'(time_sign), 0);
    cycles(20); check("t2_hold_state", int'(state), 3);
    check("t2_hold_time", int'(time_sign), 0);

    // 3: win at clk 15, step count 105 on the display
    @(negedge clk) step_cnt = 7'd105;
    start_game();
    cycles(14); check("t3_p14_time", int'(time_sign), 2);
    @(negedge clk) suc = 1'b1;
    cycles(1);  check("t3_win_state", int'(state), 2);
    check("t3_win_time", int'(time_sign), 2);
    cycles(50); check("t3_frozen_state", int'(state), 2);
    check("t3_frozen_time", int'(time_sign), 2);
    wait_cat(8'hFE, 8'h6D, "t3_ones5");
    wait_cat(8'hFD, 8'h3F, "t3_tens0");
    wait_cat(8'hFB, 8'h06, "t3_hund1");
    wait_cat(8'hF7, 8'h00, "t3_blank3");
    wait_cat(8'hEF, 8'h5B, "t3_time2");
    wait_cat(8'hDF, 8'h3F, "t3_time_tens0");
    wait_cat(8'h7F, 8'h73, "t3_glyph_win");
    @(negedge clk) suc = 1'b0;

    // 4: suc on the tick cycle
    @(negedge clk) step_cnt = 7'd9;
    start_game();
    cycles(9);
    @(negedge clk) suc = 1'b1;
    cycles(1);  check("t4_state", int'(state), 2);
    check("t4_time", int'(time_sign), 3);
    @(negedge clk) suc = 1'b0;
    cycles(15); check("t4_hold_time", int'(time_sign), 3);
    wait_cat(8'hFD, 8'h00, "t4_tens_blank");

    // 5: restart from LOSE, start held high
    start_game();
    cycles(30); check("t5_lose", int'(state), 3);
    @(negedge clk) start = 1'b1;
    cycles(1);  check("t5_restart_state", int'(state), 1);
    check("t5_restart_time", int'(time_sign), 3);
    cycles(25); check("t5_q25_time", int'(time_sign), 1);
    cycles(15); check("t5_q40_state", int'(state), 3);
    check("t5_q40_time", int'(time_sign), 0);
    @(negedge clk) start = 1'b0;

    // 6: async reset mid-run
    start_game();
    cycles(12); check("t6_pre_time", int'(time_sign), 2);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_state", int'(state), 0);
    check("t6_rst_time", int'(time_sign), 3);
    check("t6_rst_seg", int'(seg), 8'h00);
    check("t6_rst_cat", int'(cat), 8'hFF);
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    cycles(1);
    check("t6_cat_first", int'(cat), 8'hFE);
    check("t6_seg_first", int'(seg), 8'h40);

    // random play
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) start = ~start;
      suc = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0) step_cnt = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b0;
        @(negedge clk) rst = 1'b1;
      end
    end

    cycles(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
